// File: rtl/csr_pkg.sv
// Shared CSR definitions: architectural addresses, a compact index used for
// decoding, and the writable/read-only masks over that index.
package csr_pkg;

    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    typedef enum logic [3:0] {
        IDX_MTVEC,
        IDX_MSCRATCH,
        IDX_MEPC,
        IDX_MCAUSE,
        IDX_MCYCLE,
        IDX_MCYCLEH,
        IDX_MINSTRET,
        IDX_MINSTRETH,
        IDX_CYCLE,
        IDX_CYCLEH,
        IDX_INSTRET,
        IDX_INSTRETH,
        IDX_NONE
    } csr_idx_e;

    localparam int NUM_IDX = 13;

    // Bit n of each mask corresponds to csr_idx_e value n.
    localparam logic [NUM_IDX-1:0] WRITABLE_MASK  = 13'b0_0000_1111_1111;
    localparam logic [NUM_IDX-1:0] READONLY_MASK  = 13'b0_1111_0000_0000;
    localparam logic [NUM_IDX-1:0] IMPLEMENT_MASK = WRITABLE_MASK | READONLY_MASK;

    function automatic csr_idx_e csr_decode(input logic [11:0] addr);
        csr_idx_e idx;
        case (addr)
            CSR_MTVEC:     idx = IDX_MTVEC;
            CSR_MSCRATCH:  idx = IDX_MSCRATCH;
            CSR_MEPC:      idx = IDX_MEPC;
            CSR_MCAUSE:    idx = IDX_MCAUSE;
            CSR_MCYCLE:    idx = IDX_MCYCLE;
            CSR_MCYCLEH:   idx = IDX_MCYCLEH;
            CSR_MINSTRET:  idx = IDX_MINSTRET;
            CSR_MINSTRETH: idx = IDX_MINSTRETH;
            CSR_CYCLE:     idx = IDX_CYCLE;
            CSR_CYCLEH:    idx = IDX_CYCLEH;
            CSR_INSTRET:   idx = IDX_INSTRET;
            CSR_INSTRETH:  idx = IDX_INSTRETH;
            default:       idx = IDX_NONE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose halves can be overwritten independently;
// a write to either half takes priority over the increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (wr_lo) begin
            count_reg[31:0] <= wdata;
        end else if (wr_hi) begin
            count_reg[63:32] <= wdata;
        end else if (inc) begin
            count_reg <= count_reg + 64'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: trap CSRs, cycle/instret counters and their user
// read-only shadows. Reads are combinational from registered state only.
module csr_regfile #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [11:0]      csr_raddr_i,
    output logic [WIDTH-1:0] csr_rdata_o,
    input  logic             csr_we_i,
    input  logic [11:0]      csr_waddr_i,
    input  logic [WIDTH-1:0] csr_wdata_i,
    input  logic             retire_i,
    output logic             csr_illegal_o
);

    import csr_pkg::*;

    csr_idx_e ridx;
    csr_idx_e widx;
    logic     wr_ok;

    assign ridx  = csr_decode(csr_raddr_i);
    assign widx  = csr_decode(csr_waddr_i);
    assign wr_ok = csr_we_i && WRITABLE_MASK[widx];

    logic [WIDTH-1:0] mtvec_reg;
    logic [WIDTH-1:0] mscratch_reg;
    logic [WIDTH-1:0] mepc_reg;
    logic [WIDTH-1:0] mcause_reg;

    // mepc is word aligned; mtvec bit 1 is hardwired low so only direct and
    // vectored modes can be stored.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mtvec_reg    <= '0;
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
        end else if (wr_ok) begin
            case (widx)
                IDX_MTVEC:    mtvec_reg    <= csr_wdata_i & ~WIDTH'(2);
                IDX_MSCRATCH: mscratch_reg <= csr_wdata_i;
                IDX_MEPC:     mepc_reg     <= csr_wdata_i & ~WIDTH'(3);
                IDX_MCAUSE:   mcause_reg   <= csr_wdata_i;
                default:      ;
            endcase
        end
    end

    logic [31:0] wdata_lo;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    assign wdata_lo = 32'(csr_wdata_i);

    csr_counter64 u_mcycle (
        .clk   (clk_i),
        .rst   (reset_i),
        .inc   (1'b1),
        .wr_lo (wr_ok && (widx == IDX_MCYCLE)),
        .wr_hi (wr_ok && (widx == IDX_MCYCLEH)),
        .wdata (wdata_lo),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk_i),
        .rst   (reset_i),
        .inc   (retire_i),
        .wr_lo (wr_ok && (widx == IDX_MINSTRET)),
        .wr_hi (wr_ok && (widx == IDX_MINSTRETH)),
        .wdata (wdata_lo),
        .count (minstret)
    );

    always_comb begin
        csr_rdata_o = '0;
        if (!reset_i) begin
            case (ridx)
                IDX_MTVEC:                  csr_rdata_o = mtvec_reg;
                IDX_MSCRATCH:               csr_rdata_o = mscratch_reg;
                IDX_MEPC:                   csr_rdata_o = mepc_reg;
                IDX_MCAUSE:                 csr_rdata_o = mcause_reg;
                IDX_MCYCLE, IDX_CYCLE:      csr_rdata_o = WIDTH'(mcycle[31:0]);
                IDX_MCYCLEH, IDX_CYCLEH:    csr_rdata_o = WIDTH'(mcycle[63:32]);
                IDX_MINSTRET, IDX_INSTRET:  csr_rdata_o = WIDTH'(minstret[31:0]);
                IDX_MINSTRETH, IDX_INSTRETH: csr_rdata_o = WIDTH'(minstret[63:32]);
                default:                    csr_rdata_o = '0;
            endcase
        end
    end

    assign csr_illegal_o = !reset_i &&
                           (!IMPLEMENT_MASK[ridx] || (csr_we_i && !WRITABLE_MASK[widx]));

endmodule

// File: tb/tb_csr_regfile.sv
// Randomized and directed check of csr_regfile against an address-level
// model of the CSR state kept in the bench.
`timescale 1ns/1ps
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [11:0] csr_raddr_i = '0;
    logic [31:0] csr_rdata_o;
    logic        csr_we_i = 1'b0;
    logic [11:0] csr_waddr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic        retire_i = 1'b0;
    logic        csr_illegal_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #10 clk = ~clk;

    csr_regfile #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .csr_raddr_i   (csr_raddr_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_we_i      (csr_we_i),
        .csr_waddr_i   (csr_waddr_i),
        .csr_wdata_i   (csr_wdata_i),
        .retire_i      (retire_i),
        .csr_illegal_o (csr_illegal_o)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mtvec = '0, m_mscratch = '0, m_mepc = '0, m_mcause = '0;
    logic [63:0] m_cycle = '0, m_instret = '0;

    function automatic bit is_impl(input logic [11:0] a);
        return a inside {12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82,
                         12'hC00, 12'hC80, 12'hC02, 12'hC82};
    endfunction

    function automatic bit is_writable(input logic [11:0] a);
        return a inside {12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (reset_i) return 32'h0;
        case (a)
            12'h305:          return m_mtvec;
            12'h340:          return m_mscratch;
            12'h341:          return m_mepc;
            12'h342:          return m_mcause;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            default:          return 32'h0;
        endcase
    endfunction

    function automatic logic model_illegal();
        if (reset_i) return 1'b0;
        return !is_impl(csr_raddr_i) || (csr_we_i && !is_writable(csr_waddr_i));
    endfunction

    // A 64-bit counter after one clock: a write to either half replaces that
    // half and cancels the step, otherwise it adds inc modulo 2^64.
    function automatic logic [63:0] next_count(input logic [63:0] cur, input logic inc,
                                               input logic [11:0] lo_a, input logic [11:0] hi_a);
        if (csr_we_i && csr_waddr_i == lo_a) return {cur[63:32], csr_wdata_i};
        if (csr_we_i && csr_waddr_i == hi_a) return {csr_wdata_i, cur[31:0]};
        return cur + 64'(inc);
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_mtvec <= '0; m_mscratch <= '0; m_mepc <= '0; m_mcause <= '0;
            m_cycle <= '0; m_instret <= '0;
        end else begin
            m_cycle   <= next_count(m_cycle, 1'b1, 12'hB00, 12'hB80);
            m_instret <= next_count(m_instret, retire_i, 12'hB02, 12'hB82);
            if (csr_we_i) begin
                case (csr_waddr_i)
                    12'h305: m_mtvec    <= csr_wdata_i & 32'hFFFF_FFFD;
                    12'h340: m_mscratch <= csr_wdata_i;
                    12'h341: m_mepc     <= csr_wdata_i & 32'hFFFF_FFFC;
                    12'h342: m_mcause   <= csr_wdata_i;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (check_en) begin
            check("model_rdata", csr_rdata_o, model_read(csr_raddr_i));
            check("model_illegal", {31'b0, csr_illegal_o}, {31'b0, model_illegal()});
        end
    end

    task automatic slot(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                        input logic [11:0] ra, input logic rt);
        @(negedge clk);
        csr_we_i    = we;
        csr_waddr_i = wa;
        csr_wdata_i = wd;
        csr_raddr_i = ra;
        retire_i    = rt;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] exp);
        #1;
        check(name, csr_rdata_o, exp);
        $display("txn %-14s raddr=0x%03h rdata=0x%08h illegal=%0b", name, csr_raddr_i,
                 csr_rdata_o, csr_illegal_o);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [11:0] pool [16];
    logic [31:0] snap;
    logic [11:0] wa, ra;
    logic [31:0] wd;
    logic        we;

    initial begin
        pool = '{12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h000, 12'h123, 12'h7C0, 12'hFFF};

        #1 reset_i = 1'b1;
        check_en = 1'b1;

        // Outputs held low during reset, even for an illegal-looking access.
        slot(1'b1, 12'hC00, 32'h1234, 12'h123, 1'b1);
        #1 check("reset_illegal", {31'b0, csr_illegal_o}, 32'h0);
        check("reset_rdata_unimpl", csr_rdata_o, 32'h0);
        slot(1'b0, 12'h000, 32'h0, 12'h305, 1'b0);
        expect_rd("reset_mtvec", 32'h0);

        // Release, then mcycle counts 1..10, minstret stays 0.
        slot(1'b0, 12'h000, 32'h0, 12'hB00, 1'b0);
        reset_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            slot(1'b0, 12'h000, 32'h0, 12'hB00, 1'b0);
            expect_rd($sformatf("mcycle_%0d", i), 32'(i));
        end
        slot(1'b0, 12'h000, 32'h0, 12'hB02, 1'b0);
        expect_rd("minstret_idle", 32'h0);

        // Low-half write carries into the high half.
        slot(1'b1, 12'hB00, 32'hFFFF_FFFF, 12'hB00, 1'b0);
        slot(1'b0, 12'h000, 32'h0, 12'hB00, 1'b0);
        slot(1'b0, 12'h000, 32'h0, 12'hB00, 1'b0);
        slot(1'b0, 12'h000, 32'h0, 12'hB00, 1'b0);
        expect_rd("mcycle_wrap", 32'h1);
        slot(1'b0, 12'h000, 32'h0, 12'hB80, 1'b0);
        expect_rd("mcycleh_carry", 32'h1);

        // Alignment masking.
        slot(1'b1, 12'h341, 32'h8000_0003, 12'h341, 1'b0);
        expect_rd("mepc_before", 32'h0);
        slot(1'b0, 12'h000, 32'h0, 12'h341, 1'b0);
        expect_rd("mepc_masked", 32'h8000_0000);
        slot(1'b1, 12'h305, 32'h0000_1003, 12'h305, 1'b0);
        slot(1'b0, 12'h000, 32'h0, 12'h305, 1'b0);
        expect_rd("mtvec_masked", 32'h0000_1001);

        // Write wins over retire.
        slot(1'b1, 12'hB02, 32'h50, 12'hB02, 1'b1);
        slot(1'b0, 12'h000, 32'h0, 12'hB02, 1'b0);
        expect_rd("minstret_wr_wins", 32'h50);
        slot(1'b0, 12'h000, 32'h0, 12'hC02, 1'b1);
        expect_rd("instret_shadow", 32'h50);
        slot(1'b0, 12'h000, 32'h0, 12'hC02, 1'b0);
        expect_rd("instret_retired", 32'h51);

        // Write to read-only shadow: flagged, ignored, counting continues.
        slot(1'b1, 12'hC00, 32'h1234, 12'hC00, 1'b0);
        #1 check("shadow_wr_illegal", {31'b0, csr_illegal_o}, 32'h1);
        snap = m_cycle[31:0];
        slot(1'b0, 12'h000, 32'h0, 12'hC00, 1'b0);
        expect_rd("cycle_after_ro_wr", snap + 32'h1);

        // Mid-cycle reset discards an in-flight mscratch write.
        slot(1'b1, 12'h340, 32'hDEAD_BEEF, 12'h340, 1'b0);
        slot(1'b0, 12'h000, 32'h0, 12'h340, 1'b0);
        expect_rd("mscratch_wr", 32'hDEAD_BEEF);
        slot(1'b1, 12'h340, 32'h1234_5678, 12'h340, 1'b0);
        #3 reset_i = 1'b1;
        expect_rd("mscratch_in_rst", 32'h0);
        reset_i  = 1'b0;
        csr_we_i = 1'b0;
        expect_rd("mscratch_post_rst", 32'h0);
        csr_raddr_i = 12'hB00;
        expect_rd("mcycle_post_rst", 32'h0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 2000; i++) begin
            wa = pool[$urandom_range(0, 15)];
            ra = pool[$urandom_range(0, 15)];
            wd = $urandom;
            if ($urandom_range(0, 5) == 0) wd = 32'hFFFF_FFFF;
            we = ($urandom_range(0, 2) == 0);
            slot(we, wa, wd, ra, 1'($urandom_range(0, 1)));
            if (we)
                $display("txn rnd %0d write addr=0x%03h data=0x%08h read=0x%03h", i, wa, wd, ra);
        end

        @(negedge clk);
        #3 check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every CSR access port.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port csr_raddr_i  input  12  CSR read address, from the instruction's csr field.
REQ-005 SHALL have port csr_rdata_o  output  WIDTH  CSR read data, which feeds operand_b of the CSR ALU.
REQ-006 SHALL have port csr_we_i  input  1  write enable, valid in the writeback stage.
REQ-007 SHALL have port csr_waddr_i  input  12  CSR write address.
REQ-008 SHALL have port csr_wdata_i  input  WIDTH  write data, which is the CSR ALU result.
REQ-009 SHALL have port retire_i  input  1  one instruction retired this cycle.
REQ-010 SHALL have port csr_illegal_o  output  1  access to an unimplemented or read-only CSR.

Function
REQ-011 SHALL implement these CSRs: mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
REQ-012 SHALL implement read-only shadows cycle 0xC00, cycleh 0xC80, instret 0xC02 and instreth 0xC82, mirroring the m-counters.
REQ-013 SHALL make the read path combinational: csr_rdata_o reflects csr_raddr_i in the same cycle, from registered state only.
REQ-014 SHALL provide no write-to-read bypass; a same-cycle write to the address being read returns the old value, and the pipeline hazard unit handles forwarding.
REQ-015 SHALL return 0 on csr_rdata_o for a read of an unimplemented address.
REQ-016 SHALL take effect at the next rising clk_i edge when csr_we_i=1 and the address is writable.
REQ-017 SHALL force mepc bits[1:0] to 0 on write, and force mtvec bit[1] to 0 on write, so only modes 0 and 1 are representable.
REQ-018 SHALL increment the 64-bit mcycle every cycle while out of reset, wrapping from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-019 SHALL increment the 64-bit minstret by 1 on each cycle with retire_i=1, with the same wrap behaviour.
REQ-020 SHALL carry from the low half into the high half in the same cycle (a full 64-bit add).
REQ-021 SHALL, on a write to the low half of a counter, replace bits[31:0] with csr_wdata_i, hold the high half, and suppress that counter's increment that cycle.
REQ-022 SHALL, on a write to the high half of a counter, replace bits[63:32], hold the low half, and suppress that counter's increment that cycle.
REQ-023 SHALL ignore a write to a read-only shadow (0xC00-0xC82) or to an unimplemented address; state is unchanged and increments proceed normally.
REQ-024 SHALL assert csr_illegal_o combinationally when csr_raddr_i is unimplemented, or when csr_we_i=1 and csr_waddr_i is unimplemented or read-only.
REQ-025 SHALL treat retire_i=1 together with a minstret write as write-wins, with no increment.

Reset
REQ-026 SHALL, while reset_i=1, asynchronously clear every CSR to 0, including both counters.
REQ-027 SHALL force csr_rdata_o to 0 and csr_illegal_o to 0 during reset (the reset value of every output).
REQ-028 SHALL discard any write in flight when reset asserts mid-operation.
REQ-029 SHALL have mcycle read 1 in the first cycle after the first rising edge following deassertion.

Structure
REQ-030 SHALL place all CSR address constants and the writable/read-only masks in the shared package csr_pkg, alongside the existing control macros.
REQ-031 SHALL implement both 64-bit counters by instantiating the sub-module csr_counter64 twice (inputs: inc, write low, write high, wdata; output: 64-bit count).
REQ-032 SHALL keep the complete implementation within 120-400 lines of RTL.

Verification
REQ-033 SHALL cover reset release with 10 idle cycles -> mcycle reads 10 and minstret reads 0.
REQ-034 SHALL cover writing mcycle=0xFFFF_FFFF, then 2 idle cycles -> mcycle reads 0x1 and mcycleh reads 0x1.
REQ-035 SHALL cover writing mepc=0x8000_0003 -> mepc reads 0x8000_0000; writing mtvec=0x0000_1003 -> mtvec reads 0x0000_1001.
REQ-036 SHALL cover retire_i=1 with a same-cycle write minstret=0x50 -> next cycle minstret reads 0x50, not 0x51.
REQ-037 SHALL cover a write to 0xC00 with 0x1234 -> csr_illegal_o=1 that cycle, and cycle keeps incrementing from its prior value.
REQ-038 SHALL cover asserting reset_i mid-cycle while csr_we_i=1 targets mscratch -> mscratch reads 0 after reset, with no clock edge required.
